// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file access controller.
// Contents: default register-file geometry, FSM state enum, client index type.
// -----------------------------------------------------------------------------
package rf_pkg;

   localparam int RF_DATA_W   = 16;
   localparam int RF_ADDR_W   = 3;
   localparam int RF_NUM_REGS = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_SERVE = 1'b1
   } state_e;

   // Index of a requesting client (0 = decode/execute, 1 = debug/load).
   typedef logic client_t;

   localparam client_t CLIENT0 = 1'b0;
   localparam client_t CLIENT1 = 1'b1;

endpackage

// File: rtl/rf_access_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, reset (sync, active-high)
//   req_i[1:0]  requests, bit N = client N
//   en_i        arbitration enable; no grant and no pointer update when low
//   gnt_o[1:0]  one-hot combinational grant
//   ptr_o       last-granted client; resets to client 1
// -----------------------------------------------------------------------------
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o,
   output client_t    ptr_o
);

   client_t ptr_q;

   // NOTE: every output of an always_comb gets a default first so no path
   // leaves it unassigned and a latch is never inferred.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // On a tie the client that was not granted last wins.
            2'b11:   gnt_o = (ptr_q == CLIENT1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   // NOTE: sequential state is assigned with non-blocking <= so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= CLIENT1;
      end else if (gnt_o != 2'b00) begin
         ptr_q <= gnt_o[1];
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// rf_access_ctrl
// Sequencer and arbiter in front of the 8x16 register file. Zero-sweeps the
// file after reset or clear_req, then grants one of two clients per cycle
// (round-robin) access to both read ports and the write port.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   clear_req            one-cycle pulse starting a zero sweep
//   cN_req/we            client N request and write flag (N = 0, 1)
//   cN_raddr1/2, waddr   client N read/write addresses
//   cN_wdata             client N write data
//   cN_gnt               combinational grant
//   cN_rvalid            read data valid, one cycle after grant
//   cN_rdata1/2          registered read data
//   rf_raddr1/2          register-file read addresses
//   rf_rdata1/2          register-file asynchronous read data
//   rf_we/waddr/wdata    register-file write port
//   busy                 high while sweeping (and during reset)
//
// Build option: define RF_ACCESS_FWD_EN to return the new write data on a
// same-cycle, same-client read/write collision; otherwise the old register
// value is returned.
// -----------------------------------------------------------------------------
module rf_access_ctrl
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_REGS = RF_NUM_REGS   // must equal 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,

   input  logic              c0_req,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_raddr1,
   input  logic [ADDR_W-1:0] c0_raddr2,
   input  logic [ADDR_W-1:0] c0_waddr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_gnt,
   output logic              c0_rvalid,
   output logic [DATA_W-1:0] c0_rdata1,
   output logic [DATA_W-1:0] c0_rdata2,

   input  logic              c1_req,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_raddr1,
   input  logic [ADDR_W-1:0] c1_raddr2,
   input  logic [ADDR_W-1:0] c1_waddr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_gnt,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] c1_rdata1,
   output logic [DATA_W-1:0] c1_rdata2,

   output logic [ADDR_W-1:0] rf_raddr1,
   output logic [ADDR_W-1:0] rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;

   logic              serving;
   logic [1:0]        gnt;
   logic              any_gnt;
   client_t           win;
   client_t           last_gnt;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_raddr1, sel_raddr2, sel_waddr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W-1:0] rd1, rd2;

   logic [ADDR_W-1:0] raddr1_q, raddr2_q;
   logic              valid_q;
   logic [DATA_W-1:0] c0_rdata1_q, c0_rdata2_q, c1_rdata1_q, c1_rdata2_q;
   logic [DATA_W-1:0] c0_rdata1_d, c0_rdata2_d, c1_rdata1_d, c1_rdata2_d;

   // Grants only in SERVE and never during the reset cycle.
   assign serving = (state_q == ST_SERVE) && !reset;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i ({c1_req, c0_req}),
      .en_i  (serving),
      .gnt_o (gnt),
      .ptr_o (last_gnt)
   );

   assign c0_gnt  = gnt[0];
   assign c1_gnt  = gnt[1];
   assign any_gnt = |gnt;
   assign win     = gnt[1];

   // Winner's request fields; only meaningful while any_gnt is high.
   assign sel_we     = (win == CLIENT1) ? c1_we     : c0_we;
   assign sel_raddr1 = (win == CLIENT1) ? c1_raddr1 : c0_raddr1;
   assign sel_raddr2 = (win == CLIENT1) ? c1_raddr2 : c0_raddr2;
   assign sel_waddr  = (win == CLIENT1) ? c1_waddr  : c0_waddr;
   assign sel_wdata  = (win == CLIENT1) ? c1_wdata  : c0_wdata;

   // Read addresses follow the winner and otherwise hold the last grant's.
   assign rf_raddr1 = reset ? '0 : (any_gnt ? sel_raddr1 : raddr1_q);
   assign rf_raddr2 = reset ? '0 : (any_gnt ? sel_raddr2 : raddr2_q);

   // The file reads asynchronously, so rf_rdata* is the pre-write value in
   // the grant cycle; forwarding substitutes the data being written.
`ifdef RF_ACCESS_FWD_EN
   assign rd1 = (sel_we && (sel_raddr1 == sel_waddr)) ? sel_wdata : rf_rdata1;
   assign rd2 = (sel_we && (sel_raddr2 == sel_waddr)) ? sel_wdata : rf_rdata2;
`else
   assign rd1 = rf_rdata1;
   assign rd2 = rf_rdata2;
`endif

   // Write port: sweep in CLEAR, winner's write in SERVE, idle in reset.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = cnt_q;
      rf_wdata = '0;
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            rf_we = 1'b1;
         end else if (any_gnt && sel_we) begin
            rf_we    = 1'b1;
            rf_waddr = sel_waddr;
            rf_wdata = sel_wdata;
         end
      end
   end

   assign busy = reset || (state_q == ST_CLEAR);

   // FSM and sweep counter; clear_req restarts the sweep from either state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (clear_req) begin
                  cnt_q <= '0;
               end else if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_SERVE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_SERVE: begin
               if (clear_req) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Read-data capture: only the winner's registers load; the other holds.
   always_comb begin
      c0_rdata1_d = c0_rdata1_q;
      c0_rdata2_d = c0_rdata2_q;
      c1_rdata1_d = c1_rdata1_q;
      c1_rdata2_d = c1_rdata2_q;
      if (gnt[0]) begin
         c0_rdata1_d = rd1;
         c0_rdata2_d = rd2;
      end
      if (gnt[1]) begin
         c1_rdata1_d = rd1;
         c1_rdata2_d = rd2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         raddr1_q    <= '0;
         raddr2_q    <= '0;
         valid_q     <= 1'b0;
         c0_rdata1_q <= '0;
         c0_rdata2_q <= '0;
         c1_rdata1_q <= '0;
         c1_rdata2_q <= '0;
      end else begin
         valid_q     <= any_gnt;
         c0_rdata1_q <= c0_rdata1_d;
         c0_rdata2_q <= c0_rdata2_d;
         c1_rdata1_q <= c1_rdata1_d;
         c1_rdata2_q <= c1_rdata2_d;
         if (any_gnt) begin
            raddr1_q <= sel_raddr1;
            raddr2_q <= sel_raddr2;
         end
      end
   end

   // The arbiter pointer names the client granted last cycle, so it steers
   // the single valid flop to the right client.
   assign c0_rvalid = valid_q && (last_gnt == CLIENT0);
   assign c1_rvalid = valid_q && (last_gnt == CLIENT1);

   assign c0_rdata1 = c0_rdata1_q;
   assign c0_rdata2 = c0_rdata2_q;
   assign c1_rdata1 = c1_rdata1_q;
   assign c1_rdata2 = c1_rdata2_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_access_ctrl
// Directed bench for rf_access_ctrl with a behavioural 8x16 register file
// (asynchronous read, write on the rising edge when rf_we is high).
// -----------------------------------------------------------------------------
module tb_rf_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_req;
   logic        c0_req, c0_we, c1_req, c1_we;
   logic [2:0]  c0_raddr1, c0_raddr2, c0_waddr;
   logic [2:0]  c1_raddr1, c1_raddr2, c1_waddr;
   logic [15:0] c0_wdata, c1_wdata;
   logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
   logic [15:0] c0_rdata1, c0_rdata2, c1_rdata1, c1_rdata2;
   logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
   logic        rf_we, busy;

   logic [15:0] rf_mem [8];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   end
   assign rf_rdata1 = rf_mem[rf_raddr1];
   assign rf_rdata2 = rf_mem[rf_raddr2];

   rf_access_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .c0_req    (c0_req),
      .c0_we     (c0_we),
      .c0_raddr1 (c0_raddr1),
      .c0_raddr2 (c0_raddr2),
      .c0_waddr  (c0_waddr),
      .c0_wdata  (c0_wdata),
      .c0_gnt    (c0_gnt),
      .c0_rvalid (c0_rvalid),
      .c0_rdata1 (c0_rdata1),
      .c0_rdata2 (c0_rdata2),
      .c1_req    (c1_req),
      .c1_we     (c1_we),
      .c1_raddr1 (c1_raddr1),
      .c1_raddr2 (c1_raddr2),
      .c1_waddr  (c1_waddr),
      .c1_wdata  (c1_wdata),
      .c1_gnt    (c1_gnt),
      .c1_rvalid (c1_rvalid),
      .c1_rdata1 (c1_rdata1),
      .c1_rdata2 (c1_rdata2),
      .rf_raddr1 (rf_raddr1),
      .rf_raddr2 (rf_raddr2),
      .rf_rdata1 (rf_rdata1),
      .rf_rdata2 (rf_rdata2),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .busy      (busy)
   );

   // Inputs change 1 time unit after the rising edge; combinational outputs
   // are checked 1 unit later, registered outputs right after step().
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear_req = 1'b0;
      c0_req = 1'b1; c0_we = 1'b1; c0_waddr = 3'd3; c0_wdata = 16'h0333;
      c0_raddr1 = 3'd6; c0_raddr2 = 3'd7;
      c1_req = 1'b0; c1_we = 1'b0; c1_raddr1 = '0; c1_raddr2 = '0;
      c1_waddr = '0; c1_wdata = '0;
      step();
      step();
      #1;
      tests++;
      if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rf_we, busy} !== 6'b000001) begin
         fails++;
         $display("FAIL reset_ctrl: gnt/rvalid/we/busy=%b want 000001",
                  {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rf_we, busy});
      end
      tests++;
      if ({c0_rdata1, c0_rdata2, c1_rdata1, c1_rdata2} !== 64'h0) begin
         fails++;
         $display("FAIL reset_rdata: got %h want 0",
                  {c0_rdata1, c0_rdata2, c1_rdata1, c1_rdata2});
      end
      tests++;
      if ({rf_raddr1, rf_raddr2} !== 6'd0) begin
         fails++;
         $display("FAIL reset_raddr: got %h want 0", {rf_raddr1, rf_raddr2});
      end
   endtask

   // Sweep after reset release, with a client-0 write to reg 3 held off.
   task automatic test_sweep();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         tests++;
         if ({rf_we, rf_waddr, rf_wdata, busy, c0_gnt} !== {1'b1, i[2:0], 16'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sweep_%0d: we=%b waddr=%0d wdata=%h busy=%b gnt=%b want 1 %0d 0000 1 0",
                     i, rf_we, rf_waddr, rf_wdata, busy, c0_gnt, i);
         end
         step();
      end
      #1;
      tests++;
      if ({busy, c0_gnt, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 1'b1, 3'd3, 16'h0333}) begin
         fails++;
         $display("FAIL first_grant: busy=%b gnt=%b we=%b waddr=%0d wdata=%h want 0 1 1 3 0333",
                  busy, c0_gnt, rf_we, rf_waddr, rf_wdata);
      end
      step();
      c0_req = 1'b0; c0_we = 1'b0;
   endtask

   task automatic test_single();
      c0_req = 1'b1; c0_we = 1'b1; c0_waddr = 3'd5; c0_wdata = 16'hBEEF;
      #1;
      tests++;
      if ({c0_gnt, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 3'd5, 16'hBEEF}) begin
         fails++;
         $display("FAIL single_write: gnt=%b we=%b waddr=%0d wdata=%h want 1 1 5 beef",
                  c0_gnt, rf_we, rf_waddr, rf_wdata);
      end
      step();
      c0_we = 1'b0; c0_raddr1 = 3'd5; c0_raddr2 = 3'd0;
      #1;
      tests++;
      if ({c0_gnt, rf_we, rf_raddr1, rf_raddr2} !== {1'b1, 1'b0, 3'd5, 3'd0}) begin
         fails++;
         $display("FAIL single_read: gnt=%b we=%b raddr=%0d/%0d want 1 0 5/0",
                  c0_gnt, rf_we, rf_raddr1, rf_raddr2);
      end
      step();
      c0_req = 1'b0;
      tests++;
      if ({c0_rvalid, c1_rvalid, c0_rdata1, c0_rdata2} !== {1'b1, 1'b0, 16'hBEEF, 16'h0}) begin
         fails++;
         $display("FAIL single_rdata: rvalid=%b/%b rdata=%h/%h want 1/0 beef/0000",
                  c0_rvalid, c1_rvalid, c0_rdata1, c0_rdata2);
      end
      step();
      #1;
      tests++;
      if ({c0_rvalid, rf_raddr1, rf_we} !== {1'b0, 3'd5, 1'b0}) begin
         fails++;
         $display("FAIL idle_hold: rvalid=%b raddr1=%0d we=%b want 0 5 0",
                  c0_rvalid, rf_raddr1, rf_we);
      end
      // A lone client-1 read leaves client 1 as last winner.
      c1_req = 1'b1; c1_raddr1 = 3'd5; c1_raddr2 = 3'd3;
      #1;
      tests++;
      if ({c1_gnt, c0_gnt} !== 2'b10) begin
         fails++;
         $display("FAIL c1_grant: gnt1/0=%b want 10", {c1_gnt, c0_gnt});
      end
      step();
      c1_req = 1'b0;
      tests++;
      if ({c1_rvalid, c1_rdata1, c1_rdata2} !== {1'b1, 16'hBEEF, 16'h0333}) begin
         fails++;
         $display("FAIL c1_rdata: rvalid=%b rdata=%h/%h want 1 beef/0333",
                  c1_rvalid, c1_rdata1, c1_rdata2);
      end
   endtask

   task automatic test_contention();
      logic exp0;
      logic prev0;
      c0_raddr1 = 3'd3; c0_raddr2 = 3'd5;
      c1_raddr1 = 3'd5; c1_raddr2 = 3'd3;
      c0_req = 1'b1; c1_req = 1'b1;
      prev0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp0 = (k % 2 == 0);
         #1;
         tests++;
         if ({c0_gnt, c1_gnt, rf_raddr1} !== {exp0, !exp0, (exp0 ? 3'd3 : 3'd5)}) begin
            fails++;
            $display("FAIL contend_gnt_%0d: gnt0/1=%b%b raddr1=%0d want %b%b",
                     k, c0_gnt, c1_gnt, rf_raddr1, exp0, !exp0);
         end
         if (k > 0) begin
            tests++;
            if ({c0_rvalid, c1_rvalid} !== {prev0, !prev0}) begin
               fails++;
               $display("FAIL contend_rvalid_%0d: rvalid0/1=%b%b want %b%b",
                        k, c0_rvalid, c1_rvalid, prev0, !prev0);
            end
         end
         prev0 = exp0;
         step();
      end
      c0_req = 1'b0; c1_req = 1'b0;
      tests++;
      if ({c0_rvalid, c1_rvalid, c0_rdata1, c1_rdata1} !== {1'b0, 1'b1, 16'h0333, 16'hBEEF}) begin
         fails++;
         $display("FAIL contend_end: rvalid0/1=%b%b rdata=%h/%h want 01 0333/beef",
                  c0_rvalid, c1_rvalid, c0_rdata1, c1_rdata1);
      end
   endtask

   task automatic test_collision();
      logic [15:0] exp_col;
`ifdef RF_ACCESS_FWD_EN
      exp_col = 16'h1234;
`else
      exp_col = 16'h0042;
`endif
      c0_req = 1'b1; c0_we = 1'b1; c0_waddr = 3'd2; c0_wdata = 16'h0042;
      c0_raddr1 = 3'd3; c0_raddr2 = 3'd5;
      step();
      c0_req = 1'b0; c0_we = 1'b0;
      c1_req = 1'b1; c1_we = 1'b1; c1_waddr = 3'd2; c1_wdata = 16'h1234;
      c1_raddr1 = 3'd2; c1_raddr2 = 3'd5;
      #1;
      tests++;
      if ({c1_gnt, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 3'd2, 16'h1234}) begin
         fails++;
         $display("FAIL col_write: gnt=%b we=%b waddr=%0d wdata=%h want 1 1 2 1234",
                  c1_gnt, rf_we, rf_waddr, rf_wdata);
      end
      step();
      c1_req = 1'b0; c1_we = 1'b0;
      tests++;
      if ({c1_rdata1, c1_rdata2, c0_rdata1} !== {exp_col, 16'hBEEF, 16'h0333}) begin
         fails++;
         $display("FAIL col_rdata: c1=%h/%h c0_rdata1=%h want %h/beef 0333",
                  c1_rdata1, c1_rdata2, c0_rdata1, exp_col);
      end
      c0_req = 1'b1; c0_raddr1 = 3'd2; c0_raddr2 = 3'd2;
      step();
      c0_req = 1'b0;
      tests++;
      if ({c0_rdata1, c0_rdata2} !== {16'h1234, 16'h1234}) begin
         fails++;
         $display("FAIL col_visible: rdata=%h/%h want 1234/1234", c0_rdata1, c0_rdata2);
      end
   endtask

   task automatic test_clear_mid_op();
      c0_req = 1'b1; c0_raddr1 = 3'd6; c0_raddr2 = 3'd6;
      step();
      c0_raddr1 = 3'd5; c0_raddr2 = 3'd2; clear_req = 1'b1;
      #1;
      tests++;
      if ({c0_gnt, busy} !== 2'b10) begin
         fails++;
         $display("FAIL clear_grant: gnt=%b busy=%b want 1 0", c0_gnt, busy);
      end
      step();
      clear_req = 1'b0;
      tests++;
      if ({c0_rvalid, c0_rdata1, c0_rdata2} !== {1'b1, 16'hBEEF, 16'h1234}) begin
         fails++;
         $display("FAIL clear_rdata: rvalid=%b rdata=%h/%h want 1 beef/1234",
                  c0_rvalid, c0_rdata1, c0_rdata2);
      end
      for (int i = 0; i < 8; i++) begin
         #1;
         tests++;
         if ({busy, c0_gnt, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 1'b1, i[2:0], 16'h0}) begin
            fails++;
            $display("FAIL clear_sweep_%0d: busy=%b gnt=%b we=%b waddr=%0d wdata=%h want 1 0 1 %0d 0000",
                     i, busy, c0_gnt, rf_we, rf_waddr, rf_wdata, i);
         end
         step();
      end
      for (int i = 0; i < 8; i++) begin
         c0_raddr1 = i[2:0]; c0_raddr2 = 3'(7 - i);
         step();
         tests++;
         if ({c0_rvalid, c0_rdata1, c0_rdata2} !== {1'b1, 16'h0, 16'h0}) begin
            fails++;
            $display("FAIL cleared_reg_%0d: rvalid=%b rdata=%h/%h want 1 0000/0000",
                     i, c0_rvalid, c0_rdata1, c0_rdata2);
         end
      end
      c0_req = 1'b0;
   endtask

   task automatic test_clear_restart();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      step(); step(); step();
      clear_req = 1'b1;
      #1;
      tests++;
      if ({busy, rf_waddr} !== {1'b1, 3'd3}) begin
         fails++;
         $display("FAIL restart_pre: busy=%b waddr=%0d want 1 3", busy, rf_waddr);
      end
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         tests++;
         if ({busy, rf_we, rf_waddr} !== {1'b1, 1'b1, i[2:0]}) begin
            fails++;
            $display("FAIL restart_sweep_%0d: busy=%b we=%b waddr=%0d want 1 1 %0d",
                     i, busy, rf_we, rf_waddr, i);
         end
         step();
      end
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL restart_done: busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid_sweep();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      step(); step(); step(); step();
      #1;
      tests++;
      if (rf_waddr !== 3'd4) begin
         fails++;
         $display("FAIL midsweep_pos: waddr=%0d want 4", rf_waddr);
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({rf_we, busy} !== 2'b01) begin
         fails++;
         $display("FAIL midsweep_reset: we=%b busy=%b want 0 1", rf_we, busy);
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         tests++;
         if ({busy, rf_we, rf_waddr} !== {1'b1, 1'b1, i[2:0]}) begin
            fails++;
            $display("FAIL resweep_%0d: busy=%b we=%b waddr=%0d want 1 1 %0d",
                     i, busy, rf_we, rf_waddr, i);
         end
         step();
      end
      // Pointer is back at 1, so client 0 takes the first tie.
      c0_req = 1'b1; c1_req = 1'b1;
      #1;
      tests++;
      if ({busy, c0_gnt, c1_gnt} !== 3'b010) begin
         fails++;
         $display("FAIL reset_ptr: busy=%b gnt0/1=%b%b want 0 10", busy, c0_gnt, c1_gnt);
      end
      step();
      c0_req = 1'b0; c1_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf_mem[i] = 16'hA5A0 + 16'(i);
      test_reset();
      test_sweep();
      test_single();
      test_contention();
      test_collision();
      test_clear_mid_op();
      test_clear_restart();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Sequencer and arbiter in front of the 8×16 general-purpose register file. Two requesters (client 0 and client 1) share the file's two read ports and one write port. The block owns the register-file write strobe. After reset, or on request, it sweeps zeros into every register before granting any access. It sits between the decode/execute stage (client 0) and the debug/load unit (client 1) and the register file.

## Interface
Parameters:
- `DATA_W`, 16, register width.
- `ADDR_W`, 3, register address width.
- `NUM_REGS`, 8, register count; must equal 2**ADDR_W.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `clear_req`  in  1  one-cycle pulse that starts a zero sweep.
- `cN_req`  in  1  request from client N (N = 0, 1), held until granted.
- `cN_we`  in  1  the request includes a write.
- `cN_raddr1`, `cN_raddr2`  in  ADDR_W  read addresses.
- `cN_waddr`  in  ADDR_W  write address.
- `cN_wdata`  in  DATA_W  write data.
- `cN_gnt`  out  1  combinational grant; the request is consumed this cycle.
- `cN_rvalid`  out  1  read data valid, one cycle after grant.
- `cN_rdata1`, `cN_rdata2`  out  DATA_W  registered read data.
- `rf_raddr1`, `rf_raddr2`  out  ADDR_W  register-file read addresses.
- `rf_rdata1`, `rf_rdata2`  in  DATA_W  register-file asynchronous read data.
- `rf_we`  out  1  register-file write strobe.
- `rf_waddr`  out  ADDR_W  register-file write address.
- `rf_wdata`  out  DATA_W  register-file write data.
- `busy`  out  1  high while sweeping.

## Operation
- The FSM has two states: CLEAR and SERVE.
- **CLEAR**
  - `rf_we`=1, `rf_waddr`=sweep counter, `rf_wdata`=0.
  - The counter steps 0→NUM_REGS-1.
  - After the write to NUM_REGS-1, the FSM goes to SERVE.
  - `busy`=1 and no grants are issued.
- **SERVE**
  - At most one grant per cycle.
  - **Arbitration:** round-robin.
    - If only one client requests, it wins.
    - If both request, the client that was not granted last wins.
    - The last-grant pointer resets to 1, so client 0 wins the first tie.
  - The winner's read addresses drive `rf_raddr1`/`rf_raddr2`.
  - Read data is registered into the winner's `rdata1`/`rdata2`. The winner's `rvalid` pulses high for one cycle on the next cycle.
  - If the winner's `we`=1: `rf_we`=1 with the winner's `waddr` and `wdata` in the grant cycle.
  - With no grant, `rf_we`=0 and the read addresses hold their last value.
- The loser keeps its request asserted, and its `gnt` stays 0.
- **`clear_req` in SERVE:** enters CLEAR next cycle with the counter at 0. A grant issued in the same cycle as `clear_req` completes normally.
- **`clear_req` in CLEAR:** the counter restarts at 0.
- **`reset` (sync, mid-operation included):** forces CLEAR with the counter at 0 and the pointer at 1. Reset values:
  - `cN_gnt`=0, `cN_rvalid`=0, `cN_rdata*`=0.
  - `rf_we`=0 during the reset cycle; `busy`=1.
  - `rf_raddr*`=0.
- `rdata` of the non-winning client holds its previous value.

## Timing
- A sweep takes NUM_REGS cycles. The first grant is possible in cycle NUM_REGS+1 after reset is released.
- Grant is combinational from `req` in the same cycle.
- Read latency is 1 cycle from grant to `rvalid`.
- Write takes effect at the grant-cycle edge. A read of that address by either client is visible from the next grant onward.
- Throughput is one access per cycle.
- Back-to-back grants to the same client are allowed only when the other client is not requesting.

## Configuration
- `RF_ACCESS_FWD_EN`
  - **Defined:** on a grant with `we`=1 where `raddr1` or `raddr2` equals `waddr`, the corresponding `rdata` returns `wdata` (new value).
  - **Undefined:** the corresponding `rdata` returns the register-file value before the write (old value).
- Only same-cycle, same-client read/write collisions are affected.

## Structure
- Shared package `rf_pkg`:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - FSM state enum {CLEAR, SERVE}.
  - Client index typedef.
- One sub-module, `rr_arb2`: a 2-input round-robin arbiter. Inputs: req[1:0], update enable. Outputs: one-hot gnt and the pointer register.
- FSM, sweep counter and read-data capture live in the top.

## Test plan
- **Reset sweep:** reset 1 cycle, then release → `rf_we`=1 with `rf_waddr` 0..7 and `rf_wdata`=0 for 8 cycles; `busy` falls. A client-0 write to reg 3 issued during the sweep is held off until then, and then granted.
- **Single client:** c0 writes reg 5=0xBEEF, then reads raddr1=5, raddr2=0 → `c0_rvalid` 1 cycle after the read grant, `rdata1`=0xBEEF, `rdata2`=0.
- **Contention:** both clients request continuously for 4 cycles → grants alternate c0, c1, c0, c1. Each `rvalid` follows its grant by one cycle.
- **Collision:** c1 writes reg 2=0x1234 while reading raddr1=2; reg 2 previously held 0x0042 → `rdata1`=0x1234 with `RF_ACCESS_FWD_EN`, 0x0042 without.
- **Clear mid-operation:** `clear_req` while c0 is streaming → the grant in that cycle completes, then an 8-cycle sweep. All registers read 0 afterwards.
- **Reset mid-sweep:** reset at sweep step 4 → the sweep restarts at address 0, and `busy` holds for a full 8 cycles.
